// File: rtl/neptuno_i2s_tx.sv
// Parametrised I2S/TDM serialiser with a one-entry holding buffer, valid/ready handshake,
// underrun and frame-start strobes. Define I2S_LEFT_JUSTIFIED_EN for left-justified output.
module neptuno_i2s_tx #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int CHANNELS    = 2,
  parameter int BCK_DIV     = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CHANNELS*SAMPLE_BITS-1:0] sample_data,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  output logic                            underrun,
  output logic                            frame_start,
  output logic                            I2S_BCK,
  output logic                            I2S_LRCK,
  output logic                            I2S_DATA
);

  localparam int FRAME  = CHANNELS * SLOT_BITS;
  localparam int FW     = CHANNELS * SAMPLE_BITS;
  localparam int DIV_W  = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int BIT_W  = $clog2(FRAME);
  localparam int POS_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int SLOT_W = $clog2(CHANNELS);
  localparam int IDX_W  = $clog2(FW);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SLOT_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);

  logic [DIV_W-1:0]  div_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [POS_W-1:0]  pos_r;
  logic [SLOT_W-1:0] slot_r;
  logic              bck_r;
  logic              lrck_r;
  logic              data_r;
`ifndef I2S_LEFT_JUSTIFIED_EN
  logic              delay_r;
`endif
  logic [FW-1:0]     frame_r;
  logic [FW-1:0]     hold_r;
  logic              full_r;
  logic              ready_r;
  logic              underrun_r;
  logic              frame_start_r;

  logic              tick_s;
  logic              fall_s;
  logic              wrap_s;
  logic              load_s;
  logic              accept_s;
  logic [BIT_W-1:0]  bit_nxt_s;
  logic [POS_W-1:0]  pos_nxt_s;
  logic [SLOT_W-1:0] slot_nxt_s;
  logic [FW-1:0]     load_frame_s;
  logic [FW-1:0]     src_frame_s;
  logic [IDX_W-1:0]  idx_s;
  logic              stream_s;
  logic              lrck_nxt_s;

  assign tick_s       = (div_cnt_r == DIV_LAST);
  assign fall_s       = tick_s && bck_r;
  assign wrap_s       = (bit_cnt_r == BIT_LAST);
  assign load_s       = fall_s && wrap_s;
  assign accept_s     = sample_valid && ready_r;
  assign load_frame_s = full_r ? hold_r : {FW{1'b0}};
  // Bit 0 of a new frame must come from the word being loaded in the same clk.
  assign src_frame_s  = wrap_s ? load_frame_s : frame_r;
  assign lrck_nxt_s   = (int'(slot_nxt_s) >= (CHANNELS / 2));

  // Next bit position within the frame, slot and channel.
  always_comb begin
    bit_nxt_s  = bit_cnt_r;
    pos_nxt_s  = pos_r;
    slot_nxt_s = slot_r;
    if (wrap_s) begin
      bit_nxt_s  = {BIT_W{1'b0}};
      pos_nxt_s  = {POS_W{1'b0}};
      slot_nxt_s = {SLOT_W{1'b0}};
    end else if (pos_r == POS_LAST) begin
      bit_nxt_s  = bit_cnt_r + BIT_W'(1);
      pos_nxt_s  = {POS_W{1'b0}};
      slot_nxt_s = slot_r + SLOT_W'(1);
    end else begin
      bit_nxt_s  = bit_cnt_r + BIT_W'(1);
      pos_nxt_s  = pos_r + POS_W'(1);
      slot_nxt_s = slot_r;
    end
  end

  // Serial stream bit for the next position: sample MSB first, zero padding after it.
  always_comb begin
    idx_s    = IDX_W'(int'(slot_nxt_s) * SAMPLE_BITS + SAMPLE_BITS - 1 - int'(pos_nxt_s));
    stream_s = 1'b0;
    if (int'(pos_nxt_s) < SAMPLE_BITS) begin
      stream_s = src_frame_s[idx_s];
    end else begin
      stream_s = 1'b0;
    end
  end

  // Bit-clock divider, bit counters and serial pin registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bck_r     <= 1'b0;
      bit_cnt_r <= BIT_LAST;
      pos_r     <= POS_LAST;
      slot_r    <= SLOT_LAST;
      lrck_r    <= 1'b0;
      data_r    <= 1'b0;
`ifndef I2S_LEFT_JUSTIFIED_EN
      delay_r   <= 1'b0;
`endif
    end else begin
      if (tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bck_r     <= ~bck_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      if (fall_s) begin
        bit_cnt_r <= bit_nxt_s;
        pos_r     <= pos_nxt_s;
        slot_r    <= slot_nxt_s;
        lrck_r    <= lrck_nxt_s;
`ifdef I2S_LEFT_JUSTIFIED_EN
        data_r    <= stream_s;
`else
        data_r    <= delay_r;
        delay_r   <= stream_s;
`endif
      end
    end
  end

  // Holding buffer, handshake, frame register and status strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_r       <= {FW{1'b0}};
      hold_r        <= {FW{1'b0}};
      full_r        <= 1'b0;
      ready_r       <= 1'b0;
      underrun_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      ready_r       <= !full_r && !accept_s;
      underrun_r    <= load_s && !full_r;
      frame_start_r <= load_s;
      if (load_s) begin
        frame_r <= load_frame_s;
      end
      if (accept_s) begin
        hold_r <= sample_data;
      end
      // A load with an empty buffer may coincide with an accept; the sample then waits a frame.
      if (load_s && full_r) begin
        full_r <= 1'b0;
      end else if (accept_s) begin
        full_r <= 1'b1;
      end
    end
  end

  assign sample_ready = ready_r;
  assign underrun     = underrun_r;
  assign frame_start  = frame_start_r;
  assign I2S_BCK      = bck_r;
  assign I2S_LRCK     = lrck_r;
  assign I2S_DATA     = data_r;

endmodule

// File: tb/tb_neptuno_i2s_tx.sv
// Self-checking bench for neptuno_i2s_tx: vector table, random traffic against a
// position-arithmetic reference model, and directed reset / TDM sequences.
module tb_neptuno_i2s_tx;

  localparam int SB = 16;
  localparam int SL = 32;
  localparam int CH = 2;
  localparam int BD = 4;
  localparam int FR = CH * SL;
  localparam int HALF = 2 * BD;
`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam int LAG = 0;
`else
  localparam int LAG = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sample_data = 32'h0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, underrun, frame_start, bck, lrck, sdata;

  logic [63:0] sample_data4 = 64'h0;
  logic        sample_valid4 = 1'b0;
  logic        sample_ready4, underrun4, frame_start4, bck4, lrck4, sdata4;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          n;
  logic        m_full;
  logic [31:0] m_buf;
  logic        m_ready;
  logic        m_ur;
  logic        m_fs;
  logic [31:0] frames[$];

  typedef struct {
    logic [31:0] data;
    bit          give;
    logic        exp_ur;
    logic [63:0] exp_stream;
  } vec_t;

  vec_t tab[5];

  neptuno_i2s_tx dut (
    .clk(clk), .reset_n(reset_n), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .underrun(underrun), .frame_start(frame_start),
    .I2S_BCK(bck), .I2S_LRCK(lrck), .I2S_DATA(sdata)
  );

  neptuno_i2s_tx #(.SAMPLE_BITS(16), .SLOT_BITS(16), .CHANNELS(4), .BCK_DIV(1)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_data(sample_data4), .sample_valid(sample_valid4),
    .sample_ready(sample_ready4), .underrun(underrun4), .frame_start(frame_start4),
    .I2S_BCK(bck4), .I2S_LRCK(lrck4), .I2S_DATA(sdata4)
  );

  always #5 clk = ~clk;

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk64(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic stream_bit(int h);
    int f, b, slot, p;
    logic [31:0] w;
    if (h < 0) return 1'b0;
    f = h / FR;
    b = h % FR;
    slot = b / SL;
    p = b % SL;
    if (p >= SB || f >= frames.size()) return 1'b0;
    w = frames[f];
    return w[slot * SB + SB - 1 - p];
  endfunction

  task automatic model_reset();
    n = 0;
    m_full = 1'b0;
    m_buf = 32'h0;
    m_ready = 1'b0;
    m_ur = 1'b0;
    m_fs = 1'b0;
    frames.delete();
  endtask

  task automatic model_step();
    logic acc, rdy_n;
    int g;
    n++;
    acc = sample_valid && m_ready;
    rdy_n = !m_full && !acc;
    m_ur = 1'b0;
    m_fs = 1'b0;
    if (n % HALF == 0) begin
      g = n / HALF - 1;
      if (g % FR == 0) begin
        frames.push_back(m_full ? m_buf : 32'h0);
        m_ur = !m_full;
        m_fs = 1'b1;
        m_full = 1'b0;
      end
    end
    if (acc) begin
      m_full = 1'b1;
      m_buf = sample_data;
    end
    m_ready = rdy_n;
  endtask

  task automatic model_check();
    logic e_bck, e_lrck, e_data;
    int g;
    e_bck = ((n / BD) % 2) == 1;
    if (n < HALF) begin
      e_lrck = 1'b0;
      e_data = 1'b0;
    end else begin
      g = n / HALF - 1;
      e_lrck = ((g % FR) / SL) >= (CH / 2);
      e_data = stream_bit(g - LAG);
    end
    chk1("bck", bck, e_bck);
    chk1("lrck", lrck, e_lrck);
    chk1("data", sdata, e_data);
    chk1("ready", sample_ready, m_ready);
    chk1("underrun", underrun, m_ur);
    chk1("frame_start", frame_start, m_fs);
  endtask

  task automatic check_zero(string tag);
    chk1({tag, "_bck"}, bck, 1'b0);
    chk1({tag, "_lrck"}, lrck, 1'b0);
    chk1({tag, "_data"}, sdata, 1'b0);
    chk1({tag, "_ready"}, sample_ready, 1'b0);
    chk1({tag, "_underrun"}, underrun, 1'b0);
    chk1({tag, "_frame_start"}, frame_start, 1'b0);
    chk1({tag, "_bck4"}, bck4, 1'b0);
    chk1({tag, "_ready4"}, sample_ready4, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (!reset_n) begin
      check_zero("rst");
    end else begin
      model_step();
      model_check();
    end
  endtask

  task automatic wait_fs(output bit ok);
    int cnt;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 2 * FR * HALF + 8) begin
      tick();
      cnt++;
      if (frame_start) ok = 1'b1;
    end
    if (!ok) chk1("frame_start_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_fs4(output bit ok);
    int cnt;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 300) begin
      tick();
      cnt++;
      if (frame_start4) ok = 1'b1;
    end
    if (!ok) chk1("frame_start4_timeout", 1'b0, 1'b1);
  endtask

  task automatic give(logic [31:0] d);
    bit done;
    int cnt;
    logic rdy;
    sample_data = d;
    sample_valid = 1'b1;
    done = 1'b0;
    cnt = 0;
    while (!done && cnt < 2 * FR * HALF) begin
      rdy = sample_ready;
      tick();
      cnt++;
      if (rdy) done = 1'b1;
    end
    sample_valid = 1'b0;
    if (!done) chk1("accept_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, steps;
    logic [63:0] cd, cl;
    logic rdy;

    tab[0] = '{32'h8001_1234, 1'b1, 1'b0, {16'h1234, 16'h0000, 16'h8001, 16'h0000}};
    tab[1] = '{32'h0000_0000, 1'b0, 1'b1, 64'h0};
    tab[2] = '{32'h0000_0000, 1'b0, 1'b1, 64'h0};
    tab[3] = '{32'hFFFF_0000, 1'b1, 1'b0, {16'h0000, 16'h0000, 16'hFFFF, 16'h0000}};
    tab[4] = '{32'h0001_8000, 1'b1, 1'b0, {16'h8000, 16'h0000, 16'h0001, 16'h0000}};

    model_reset();
    repeat (10) tick();
    reset_n = 1'b1;
    model_reset();

    // vector table: one frame per record
    for (int i = 0; i < 5; i++) begin
      if (tab[i].give) give(tab[i].data);
      wait_fs(ok);
      if (ok) begin
        chk1($sformatf("vec%0d_underrun", i), underrun, tab[i].exp_ur);
        cd[63] = sdata;
        cl[63] = lrck;
        for (int b = 1; b < 64; b++) begin
          repeat (HALF) tick();
          cd[63 - b] = sdata;
          cl[63 - b] = lrck;
        end
        chk64($sformatf("vec%0d_data", i), cd, tab[i].exp_stream >> LAG);
        chk64($sformatf("vec%0d_lrck", i), cl, {32'h0, 32'hFFFF_FFFF});
      end
    end

    // random traffic against the model
    for (int i = 0; i < 3 * FR * HALF; i++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_data = $urandom;
      tick();
    end
    sample_valid = 1'b0;

    // valid held high: exactly one accept per frame
    wait_fs(ok);
    sample_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      steps = 0;
      ok = 1'b0;
      while (!ok && steps < FR * HALF + 8) begin
        rdy = sample_ready;
        if (rdy) cnt++;
        sample_data = $urandom;
        tick();
        steps++;
        if (frame_start) ok = 1'b1;
      end
      chk1($sformatf("hold_valid_fs%0d", f), ok, 1'b1);
      chk64($sformatf("accepts_frame%0d", f), 64'(cnt), 64'd1);
    end
    sample_valid = 1'b0;

    // reset pulsed mid-frame at bit 20
    wait_fs(ok);
    repeat (20 * HALF) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async");
    repeat (4) tick();
    reset_n = 1'b1;
    model_reset();
    wait_fs(ok);
    if (ok) chk1("post_reset_underrun", underrun, 1'b1);

    // 4-channel TDM, 16-bit slots, BCK_DIV=1: channel 2 = 0x8000
    wait_fs4(ok);
    sample_data4 = {16'h0000, 16'h8000, 16'h0000, 16'h0000};
    sample_valid4 = 1'b1;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 20) begin
      rdy = sample_ready4;
      tick();
      cnt++;
      if (rdy) ok = 1'b1;
    end
    sample_valid4 = 1'b0;
    chk1("tdm_accept", ok, 1'b1);
    wait_fs4(ok);
    if (ok) begin
      chk1("tdm_underrun", underrun4, 1'b0);
      chk1("tdm_bck_lo", bck4, 1'b0);
      cd[63] = sdata4;
      cl[63] = lrck4;
      for (int b = 1; b < 64; b++) begin
        tick();
        if (b == 1) chk1("tdm_bck_hi", bck4, 1'b1);
        tick();
        cd[63 - b] = sdata4;
        cl[63 - b] = lrck4;
      end
      chk64("tdm_data", cd, 64'h0000_0000_8000_0000 >> LAG);
      chk64("tdm_lrck", cl, {32'h0, 32'hFFFF_FFFF});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
